// File: rtl/frame_ctl.sv
// frame_ctl: once-per-frame controller for the display pipeline.
// On each rising edge of vertical blank it latches a clamped mouse position,
// detects a left-button click and steps the MENU/PLAY/OVER screen FSM.
// Every output is registered, so the path from vblnk rise to any output is one pclk.
module frame_ctl #(
    parameter int H_MAX       = 1280,
    parameter int V_MAX       = 1024,
    parameter int BTN_X0      = 576,
    parameter int BTN_X1      = 703,
    parameter int BTN_Y0      = 480,
    parameter int BTN_Y1      = 543,
    parameter int PLAY_FRAMES = 3600,
    parameter int OVER_FRAMES = 180
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        mouse_left_in,
    input  logic        hit_in,
    output logic [11:0] xpos_out,
    output logic [11:0] ypos_out,
    output logic        frame_tick,
    output logic        left_click_out,
    output logic [1:0]  screen_sel,
    output logic [15:0] frame_cnt_out
);

    // Screen encoding doubles as the screen_sel value driven to the output mux.
    typedef enum logic [1:0] {
        ST_MENU = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    localparam logic [11:0] X_LAST     = 12'(H_MAX - 1);
    localparam logic [11:0] Y_LAST     = 12'(V_MAX - 1);
    localparam logic [11:0] BTN_X_LO   = 12'(BTN_X0);
    localparam logic [11:0] BTN_X_HI   = 12'(BTN_X1);
    localparam logic [11:0] BTN_Y_LO   = 12'(BTN_Y0);
    localparam logic [11:0] BTN_Y_HI   = 12'(BTN_Y1);
    localparam logic [15:0] PLAY_LAST  = 16'(PLAY_FRAMES - 1);
    localparam logic [15:0] OVER_LAST  = 16'(OVER_FRAMES - 1);
    localparam logic [15:0] CNT_SAT    = 16'hFFFF;

    // Registered state
    state_t      r_state;
    logic        r_vblnk_d;
    logic        r_btn_prev;
    logic        r_hit_pend;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_over_cnt;
    logic [11:0] r_xpos;
    logic [11:0] r_ypos;
    logic        r_frame_tick;
    logic        r_left_click;

    // Combinational helpers
    logic        w_tick;
    logic        w_click;
    logic        w_inside;
    logic        w_hit;
    logic [11:0] w_xpos_clamp;
    logic [11:0] w_ypos_clamp;
    state_t      w_state_next;
    logic [15:0] w_frame_cnt_next;
    logic [15:0] w_over_cnt_next;

    // A tick is the first cycle of vertical blank; vblnk_d resets high so a
    // blank already in progress at reset release does not count.
    assign w_tick = vblnk_in & ~r_vblnk_d;

    // Mouse may run past the visible area; pin it to the last visible pixel.
    assign w_xpos_clamp = (xpos_in > X_LAST) ? X_LAST : xpos_in;
    assign w_ypos_clamp = (ypos_in > Y_LAST) ? Y_LAST : ypos_in;

    // Click is a rising level of the button as seen from one frame to the next.
    assign w_click = mouse_left_in & ~r_btn_prev;

    // Start-button hit test uses the clamped position of this tick.
    assign w_inside = (w_xpos_clamp >= BTN_X_LO) && (w_xpos_clamp <= BTN_X_HI) &&
                      (w_ypos_clamp >= BTN_Y_LO) && (w_ypos_clamp <= BTN_Y_HI);

    // A hit arriving exactly on the tick edge must still end the game.
    assign w_hit = r_hit_pend | hit_in;

    // Vertical blank delay register for edge detection.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_vblnk_d <= 1'b1;
        end else begin
            r_vblnk_d <= vblnk_in;
        end
    end

    // One-cycle strobes that follow the tick edge.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
            r_left_click <= 1'b0;
        end else begin
            r_frame_tick <= w_tick;
            r_left_click <= w_tick & w_click;
        end
    end

    // Frame-stable mouse snapshot and button history, refreshed once per frame.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_xpos     <= 12'd0;
            r_ypos     <= 12'd0;
            r_btn_prev <= 1'b0;
        end else if (w_tick) begin
            r_xpos     <= w_xpos_clamp;
            r_ypos     <= w_ypos_clamp;
            r_btn_prev <= mouse_left_in;
        end
    end

    // Collision memory for the current frame; only meaningful while playing.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_hit_pend <= 1'b0;
        end else if (w_tick || (r_state != ST_PLAY)) begin
            r_hit_pend <= 1'b0;
        end else if (hit_in) begin
            r_hit_pend <= 1'b1;
        end
    end

    // Screen FSM state and frame counters.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_MENU;
            r_frame_cnt <= 16'd0;
            r_over_cnt  <= 16'd0;
        end else begin
            r_state     <= w_state_next;
            r_frame_cnt <= w_frame_cnt_next;
            r_over_cnt  <= w_over_cnt_next;
        end
    end

    // Next-state and counter logic; nothing moves except on a tick.
    always_comb begin
        w_state_next     = r_state;
        w_frame_cnt_next = r_frame_cnt;
        w_over_cnt_next  = r_over_cnt;
        if (w_tick) begin
            case (r_state)
                ST_MENU: begin
                    if (w_click && w_inside) begin
                        w_state_next     = ST_PLAY;
                        w_frame_cnt_next = 16'd0;
                    end
                end
                ST_PLAY: begin
                    if (w_hit || (r_frame_cnt == PLAY_LAST)) begin
                        // frame_cnt is left as-is so OVER can show the score
                        w_state_next    = ST_OVER;
                        w_over_cnt_next = 16'd0;
                    end else if (r_frame_cnt != CNT_SAT) begin
                        w_frame_cnt_next = r_frame_cnt + 16'd1;
                    end
                end
                ST_OVER: begin
                    if (w_click || (r_over_cnt == OVER_LAST)) begin
                        w_state_next = ST_MENU;
                    end else begin
                        w_over_cnt_next = r_over_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state_next = ST_MENU;
                end
            endcase
        end
    end

    assign xpos_out       = r_xpos;
    assign ypos_out       = r_ypos;
    assign frame_tick     = r_frame_tick;
    assign left_click_out = r_left_click;
    assign screen_sel     = r_state;
    assign frame_cnt_out  = r_frame_cnt;

endmodule
